// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Assembles a serial byte stream into 32-bit instructions and writes them
//   into instruction memory at consecutive word addresses. A session starts with
//   a Start_i pulse. It ends on an all-zero end marker (Done_o). It aborts on an
//   unsupported opcode or on memory overflow (Error_o / Error_Code_o).
//
// Handshake: a byte transfers on a rising edge where Byte_Valid_i=1 and
//   Byte_Ready_o=1. Byte_Ready_o is high only while collecting bytes.
//   Byte_Valid_i may drop at any time; a drop only stalls collection.
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   synchronous, active-low
//   Start_i       in   begin a new load session (next cycle: COLLECT)
//   Byte_i        in   [7:0]  serial program byte
//   Byte_Valid_i  in   Byte_i valid
//   Byte_Ready_o  out  byte accepted this cycle if valid
//   Word_o        out  [31:0] assembled word (little-endian byte order)
//   Word_Addr_o   out  [ADDR_WIDTH-1:0] write address
//   Word_We_o     out  one-cycle memory write strobe
//   Done_o        out  session ended by end marker
//   Error_o       out  session aborted
//   Error_Code_o  out  [1:0] 00 none, 01 bad opcode, 10 overflow
//   Count_o       out  [ADDR_WIDTH:0] words written this session
//   state_dbg     out  [2:0] current FSM state (encoding of state_t)
// -----------------------------------------------------------------------------
module instr_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start_i,
   input  logic [7:0]            Byte_i,
   input  logic                  Byte_Valid_i,
   output logic                  Byte_Ready_o,
   output logic [31:0]           Word_o,
   output logic [ADDR_WIDTH-1:0] Word_Addr_o,
   output logic                  Word_We_o,
   output logic                  Done_o,
   output logic                  Error_o,
   output logic [1:0]            Error_Code_o,
   output logic [ADDR_WIDTH:0]   Count_o,
   output logic [2:0]            state_dbg
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      CHECK   = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4,
      ERROR   = 3'd5
   } state_t;

   // Memory depth 2^ADDR_WIDTH expressed in the counter's own width.
   localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_OPCODE   = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;

   state_t                state_q, state_n;
   logic [1:0]            byte_cnt_q, byte_cnt_n;
   logic [31:0]           word_q, word_n;
   logic [ADDR_WIDTH:0]   count_q, count_n;
   logic [1:0]            err_q, err_n;

   // Supported RV32I major opcodes (R, I-ALU, LOAD, STORE, BRANCH, LUI, JAL, JALR).
   function automatic logic opcode_ok(input logic [6:0] op);
      case (op)
         7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
         7'b1100011, 7'b0110111, 7'b1101111, 7'b1100111: opcode_ok = 1'b1;
         default:                                        opcode_ok = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         byte_cnt_q <= 2'd0;
         word_q     <= 32'd0;
         count_q    <= '0;
         err_q      <= ERR_NONE;
      end else begin
         state_q    <= state_n;
         byte_cnt_q <= byte_cnt_n;
         word_q     <= word_n;
         count_q    <= count_n;
         err_q      <= err_n;
      end
   end

   always_comb begin
      state_n    = state_q;
      byte_cnt_n = byte_cnt_q;
      word_n     = word_q;
      count_n    = count_q;
      err_n      = err_q;

      // Start overrides every state. A WRITE in this cycle has already
      // driven its strobe, because the strobe is decoded from the current state.
      if (Start_i) begin
         state_n    = COLLECT;
         byte_cnt_n = 2'd0;
         word_n     = 32'd0;
         count_n    = '0;
         err_n      = ERR_NONE;
      end else begin
         case (state_q)
            COLLECT: begin
               if (Byte_Valid_i) begin
                  word_n[{byte_cnt_q, 3'b000} +: 8] = Byte_i;
                  byte_cnt_n = byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) state_n = CHECK;
               end
            end
            CHECK: begin
               if (word_q == 32'd0) begin
                  state_n = DONE;
               end else if (!opcode_ok(word_q[6:0])) begin
                  state_n = ERROR;
                  err_n   = ERR_OPCODE;
               end else if (count_q == DEPTH) begin
                  state_n = ERROR;
                  err_n   = ERR_OVERFLOW;
               end else begin
                  state_n = WRITE;
               end
            end
            WRITE: begin
               count_n = count_q + COUNT_ONE;
               state_n = COLLECT;
            end
            default: ; // IDLE, DONE, ERROR hold everything
         endcase
      end
   end

   assign Byte_Ready_o = (state_q == COLLECT);
   assign Word_We_o    = (state_q == WRITE);
   assign Done_o       = (state_q == DONE);
   assign Error_o      = (state_q == ERROR);
   assign Word_o       = word_q;
   assign Word_Addr_o  = count_q[ADDR_WIDTH-1:0];
   assign Error_Code_o = err_q;
   assign Count_o      = count_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Two loaders share one stimulus stream: dut (ADDR_WIDTH=8) and dut2
//   (ADDR_WIDTH=2, depth 4, used for the overflow case). Memory writes are
//   checked against per-instance expected queues of {address, word}.
// -----------------------------------------------------------------------------
module tb_instr_loader;

   localparam logic [2:0] S_IDLE = 3'd0, S_COLLECT = 3'd1, S_CHECK = 3'd2,
                          S_WRITE = 3'd3, S_DONE = 3'd4, S_ERROR = 3'd5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;

   logic        ready, we, done, err;
   logic [31:0] word;
   logic [7:0]  addr;
   logic [1:0]  code;
   logic [8:0]  count;
   logic [2:0]  dbg;

   logic        ready2, we2, done2, err2;
   logic [31:0] word2;
   logic [1:0]  addr2;
   logic [1:0]  code2;
   logic [2:0]  count2;
   logic [2:0]  dbg2;

   instr_loader #(.ADDR_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .Start_i(start), .Byte_i(byte_in),
      .Byte_Valid_i(byte_valid), .Byte_Ready_o(ready), .Word_o(word),
      .Word_Addr_o(addr), .Word_We_o(we), .Done_o(done), .Error_o(err),
      .Error_Code_o(code), .Count_o(count), .state_dbg(dbg)
   );

   instr_loader #(.ADDR_WIDTH(2)) dut2 (
      .clk(clk), .reset(reset), .Start_i(start), .Byte_i(byte_in),
      .Byte_Valid_i(byte_valid), .Byte_Ready_o(ready2), .Word_o(word2),
      .Word_Addr_o(addr2), .Word_We_o(we2), .Done_o(done2), .Error_o(err2),
      .Error_Code_o(code2), .Count_o(count2), .state_dbg(dbg2)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [39:0] exp_q[$];
   logic [39:0] exp2_q[$];

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_write(input logic [7:0] a, input logic [31:0] w, input logic both);
      exp_q.push_back({a, w});
      if (both) exp2_q.push_back({6'd0, a, w});
   endtask

   // Every strobe seen must match the oldest expected write.
   always @(negedge clk) begin
      if (we === 1'b1) begin
         if (exp_q.size() == 0) check("unexpected_write", {addr, word}, 40'd0);
         else check("write", {addr, word}, exp_q.pop_front());
      end
      if (we2 === 1'b1) begin
         if (exp2_q.size() == 0) check("unexpected_write2", {6'd0, addr2, word2}, 40'd0);
         else check("write2", {6'd0, addr2, word2}, exp2_q.pop_front());
      end
   end

   // ---------------- driver tasks (called at a negedge, return at a negedge) ----
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic rdy;
      int   n;
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      byte_in    = b;
      byte_valid = 1'b1;
      n = 0;
      forever begin
         rdy = ready;
         @(negedge clk);
         if (rdy) break;
         n++;
         if (n > 50) begin
            check("byte_accept_timeout", 40'd0, 40'd1);
            break;
         end
      end
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] b;
         b = w[8*i +: 8];
         send_byte(b, (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_state", {37'd0, dbg}, {37'd0, S_IDLE});
      check("rst_outs", {33'd0, ready, we, done, err, code, 1'b0},  40'd0);
      check("rst_word", {8'd0, word}, 40'd0);
      check("rst_count_addr", {23'd0, count, addr}, 40'd0);
      check("rst2_count", {37'd0, count2}, 40'd0);
      reset = 1'b1;

      // Basic load: one instruction, then end marker
      pulse_start();
      check("start_collect", {36'd0, ready, dbg}, {36'd0, 1'b1, S_COLLECT});
      expect_write(8'd0, 32'h0050_0093, 1'b1);
      send_word(32'h0050_0093, 0);
      check("check_state", {36'd0, ready, dbg}, {36'd0, 1'b0, S_CHECK});
      check("check_no_we", {39'd0, we}, 40'd0);
      @(negedge clk);
      check("write_state", {36'd0, we, dbg}, {36'd0, 1'b1, S_WRITE});
      @(negedge clk);
      check("after_write", {28'd0, dbg, count}, {28'd0, S_COLLECT, 9'd1});
      send_word(32'h0000_0000, 0);
      @(negedge clk);
      check("done", {36'd0, done, err, code}, {36'd0, 1'b1, 1'b0, 2'b00});
      check("done_count", {31'd0, count}, 40'd1);
      byte_in = 8'h13; byte_valid = 1'b1;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      check("done_hold", {27'd0, ready, dbg, count}, {27'd0, 1'b0, S_DONE, 9'd1});

      // Unsupported opcode
      pulse_start();
      check("restart_clear", {29'd0, done, code, count}, 40'd0);
      send_word(32'h0000_007F, 0);
      @(negedge clk);
      check("bad_op", {35'd0, err, code, ready, done}, {35'd0, 1'b1, 2'b01, 1'b0, 1'b0});
      check("bad_op_count", {31'd0, count}, 40'd0);
      check("bad_op2", {37'd0, err2, code2}, {37'd0, 1'b1, 2'b01});
      @(negedge clk);
      check("err_hold", {35'd0, dbg, code}, {35'd0, S_ERROR, 2'b01});

      // Start in mid-word discards the partial word
      pulse_start();
      check("start_clears_code", {38'd0, code}, 40'd0);
      send_byte(8'h93, 0);
      send_byte(8'h00, 0);
      pulse_start();
      expect_write(8'd0, 32'h0000_0013, 1'b1);
      send_word(32'h0000_0013, 0);
      send_word(32'h0000_0000, 0);
      @(negedge clk);
      check("mid_restart_done", {31'd0, done, count}, {31'd0, 1'b1, 9'd1});

      // Start during WRITE: strobe completes, counter restarts from 0
      pulse_start();
      expect_write(8'd0, 32'h0000_0013, 1'b1);
      send_word(32'h0000_0013, 0);
      @(negedge clk);
      check("pre_write", {37'd0, dbg}, {37'd0, S_WRITE});
      pulse_start();
      check("start_in_write", {28'd0, dbg, count}, {28'd0, S_COLLECT, 9'd0});

      // Reset mid-word, then bytes ignored until Start
      send_byte(8'h93, 0);
      send_byte(8'h00, 0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("rst_mid", {26'd0, dbg, ready, we, done, err, code, count},
            {26'd0, S_IDLE, 11'd0});
      check("rst_mid_word", {8'd0, word}, 40'd0);
      byte_in = 8'h55; byte_valid = 1'b1;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      check("idle_ignores", {8'd0, word}, 40'd0);
      check("idle_hold", {36'd0, ready, dbg}, {36'd0, 1'b0, S_IDLE});

      // Reset during WRITE drops the strobe
      pulse_start();
      expect_write(8'd0, 32'h0000_0013, 1'b1);
      send_word(32'h0000_0013, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("rst_in_write", {27'd0, we, dbg, count}, {27'd0, 1'b0, S_IDLE, 9'd0});

      // Overflow on the 4-deep instance; the 256-deep one keeps writing
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         expect_write(i[7:0], 32'h0000_0013, (i < 4));
         send_word(32'h0000_0013, 0);
      end
      @(negedge clk);
      check("overflow2", {34'd0, err2, code2, count2}, {34'd0, 1'b1, 2'b10, 3'd4});
      check("overflow2_we", {39'd0, we2}, 40'd0);
      check("no_overflow_big", {37'd0, dbg}, {37'd0, S_WRITE});
      @(negedge clk);
      check("big_count", {31'd0, count}, 40'd5);

      // Gapped stream gives the same result as the back-to-back one
      pulse_start();
      expect_write(8'd0, 32'h0050_0093, 1'b1);
      send_word(32'h0050_0093, 3);
      send_word(32'h0000_0000, 3);
      @(negedge clk);
      check("gap_done", {31'd0, done, count}, {31'd0, 1'b1, 9'd1});
      check("gap_done2", {36'd0, done2, count2}, {36'd0, 1'b1, 3'd1});

      @(negedge clk);
      check("exp_q_empty", 40'(exp_q.size()), 40'd0);
      check("exp2_q_empty", 40'(exp2_q.size()), 40'd0);

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8: instruction-memory word-address width (depth 2^ADDR_WIDTH words).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have port Start_i  input  1  one-cycle pulse that begins a load session.
REQ-005 The block SHALL have port Byte_i  input  8  serial program byte.
REQ-006 The block SHALL have port Byte_Valid_i  input  1  Byte_i holds a valid byte.
REQ-007 The block SHALL have port Byte_Ready_o  output  1  block can accept a byte this cycle.
REQ-008 The block SHALL have port Word_o  output  32  assembled instruction word to memory.
REQ-009 The block SHALL have port Word_Addr_o  output  ADDR_WIDTH  word address for Word_o.
REQ-010 The block SHALL have port Word_We_o  output  1  one-cycle memory write strobe.
REQ-011 The block SHALL have port Done_o  output  1  session ended by end marker.
REQ-012 The block SHALL have port Error_o  output  1  session aborted by error.
REQ-013 The block SHALL have port Error_Code_o  output  2  00 none, 01 unsupported opcode, 10 memory overflow.
REQ-014 The block SHALL have port Count_o  output  ADDR_WIDTH+1  words written this session.

Function
REQ-015 States SHALL be IDLE, COLLECT, CHECK, WRITE, DONE, ERROR.
REQ-016 A byte SHALL transfer only in a cycle with Byte_Valid_i=1 and Byte_Ready_o=1; Byte_Ready_o SHALL be 1 only in COLLECT.
REQ-017 Bytes SHALL assemble little-endian: first accepted byte into Word_o[7:0], fourth into Word_o[31:24]; a 2-bit byte counter tracks position.
REQ-018 After the fourth byte is accepted, the next state SHALL be CHECK (one cycle, no byte accepted).
REQ-019 In CHECK, priority: word == 0x00000000 -> DONE (not written); else Word_o[6:0] not in {0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 1101111, 1100111} -> ERROR, code 01; else Count_o == 2^ADDR_WIDTH -> ERROR, code 10; else -> WRITE.
REQ-020 WRITE SHALL last exactly one cycle with Word_We_o=1, Word_Addr_o=Count_o[ADDR_WIDTH-1:0], Word_o stable; next cycle Count_o increments by 1 and state returns to COLLECT.
REQ-021 Word_We_o SHALL be 0 in every state other than WRITE; no write SHALL occur for the end marker or an erroring word.
REQ-022 Done_o SHALL be 1 exactly while in DONE; Error_o SHALL be 1 exactly while in ERROR; Error_Code_o SHALL hold its value until the next Start_i or reset.
REQ-023 IDLE, DONE and ERROR SHALL hold state, keep Count_o, and ignore Byte_Valid_i.
REQ-024 Start_i=1 in any state SHALL, next cycle, enter COLLECT with Count_o=0, byte counter=0, Error_Code_o=00, discarding any partial word; a WRITE in progress that cycle still completes its strobe.
REQ-025 Per accepted word, minimum throughput SHALL be 6 cycles (4 accept, CHECK, WRITE); Byte_Valid_i gaps SHALL only stall COLLECT.

Reset
REQ-026 With reset=0 at a rising edge, the block SHALL enter IDLE with Byte_Ready_o=0, Word_o=0, Word_Addr_o=0, Word_We_o=0, Done_o=0, Error_o=0, Error_Code_o=00, Count_o=0, byte counter=0.
REQ-027 Reset SHALL override Start_i and abort any state, including mid-word and WRITE (strobe dropped next cycle).

Verification
REQ-028 Start, bytes 93 00 50 00 then 00 00 00 00 -> one Word_We_o pulse, Word_o=0x00500093, Word_Addr_o=0; then Done_o=1, Count_o=1.
REQ-029 Start, bytes 7F 00 00 00 -> no write, Error_o=1, Error_Code_o=01, Count_o=0, Byte_Ready_o=0.
REQ-030 ADDR_WIDTH=2, five words 0x00000013 -> writes to addresses 0..3, fifth word gives Error_Code_o=10, Count_o=4.
REQ-031 Start, bytes 93 00 then Start_i pulse, then 13 00 00 00, 00 00 00 00 -> single write Word_o=0x00000013 at address 0, Done_o=1.
REQ-032 reset=0 after two bytes of a word -> next cycle all outputs at reset values; Byte_Valid_i ignored until Start_i.
REQ-033 Random Byte_Valid_i gaps on the REQ-028 stream -> identical writes and final state; no byte lost or duplicated.
